// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 2-flop synchronizer, framing FSM, 1-entry holding register.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling around mid-bit (+1 clk latency).
`timescale 1ns/1ps
module uart_rx_param #(
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] received_data,
  output logic                  data_is_valid,
  input  logic                  i_ready,
  output logic                  rx_error,
  output logic                  frame_error,
  output logic                  overrun,
  output logic                  o_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH + 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
  // One extra cycle so the decision point sees mid-1, mid and mid+1.
  localparam int SW = 4;
  localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2);
`else
  localparam int SW = 3;
  localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);
`endif
  localparam logic [CW-1:0] FULL_LD   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  perr;
    logic                  ferr;
  } word_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cyc_cnt, cyc_nxt;
  logic [BW-1:0]         bit_cnt, bit_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic                  perr, perr_nxt, ferr, ferr_nxt;
  logic [SW-1:0]         sync_q;  // [1:0] synchronizer, upper bits are history of the synced line
  logic                  fall, bit_val, tick, load, accept, exp_par;
  word_t                 hold;

  assign fall = sync_q[2] & ~sync_q[1];
`ifdef UART_RX_MAJORITY_VOTE_EN
  assign bit_val = (sync_q[1] & sync_q[2]) | (sync_q[1] & sync_q[3]) | (sync_q[2] & sync_q[3]);
`else
  assign bit_val = sync_q[1];
`endif
  assign tick    = (cyc_cnt == '0);
  assign exp_par = (PARITY_MODE == 2) ? ~^shreg : ^shreg;
  assign accept  = data_is_valid & i_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '1;
      state   <= IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SW-2:0], serial_in};
      state   <= state_nxt;
      cyc_cnt <= cyc_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
      perr    <= perr_nxt;
      ferr    <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    perr_nxt  = perr;
    ferr_nxt  = ferr;
    load      = 1'b0;
    if (state != IDLE && !tick) cyc_nxt = cyc_cnt - 1'b1;
    case (state)
      IDLE: if (fall) begin
        state_nxt = START;
        cyc_nxt   = HALF_LD;
        perr_nxt  = 1'b0;
        ferr_nxt  = 1'b0;
      end
      START: if (tick) begin
        if (bit_val) begin
          state_nxt = IDLE;
          cyc_nxt   = '0;
        end else begin
          state_nxt = DATA;
          cyc_nxt   = FULL_LD;
        end
      end
      DATA: if (tick) begin
        shreg_nxt = {bit_val, shreg[DATA_WIDTH-1:1]};
        cyc_nxt   = FULL_LD;
        if (bit_cnt == DATA_LAST) begin
          bit_nxt   = '0;
          state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
        end else begin
          bit_nxt = bit_cnt + 1'b1;
        end
      end
      PARITY: if (tick) begin
        perr_nxt  = (bit_val != exp_par);
        cyc_nxt   = FULL_LD;
        state_nxt = STOP;
      end
      STOP: if (tick) begin
        if (!bit_val) ferr_nxt = 1'b1;
        cyc_nxt = FULL_LD;
        if (bit_cnt == STOP_LAST) begin
          bit_nxt   = '0;
          cyc_nxt   = '0;
          state_nxt = IDLE;
          load      = 1'b1;
        end else begin
          bit_nxt = bit_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Holding register: a load only lands when the slot is empty or being drained this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold          <= '0;
      data_is_valid <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (load && (!data_is_valid || accept)) begin
        hold          <= {shreg, perr, ferr_nxt};
        data_is_valid <= 1'b1;
      end else if (accept) begin
        data_is_valid <= 1'b0;
      end
      if (accept)                     overrun <= 1'b0;
      else if (load && data_is_valid) overrun <= 1'b1;
    end
  end

  assign received_data = hold.data;
  assign rx_error      = hold.perr;
  assign frame_error   = hold.ferr;
  assign o_busy        = (state != IDLE);
endmodule
